mult_div_seq: RTL and testbench



---
 rtl/mult_div_pkg.sv | 14 +
 rtl/mds_iter_step.sv | 38 +++
 rtl/mult_div_seq.sv | 126 ++++++++++++
 tb/tb_mult_div_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the MULT/DIV sequencer.
//   mds_state_t : sequencer state encoding (also exported on the debug port)
//   OP_MULT/OP_DIV : encoding of the Op select input
//   MDS_ITER : number of shift-add / shift-subtract iterations per operation
package mult_div_pkg;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} mds_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MDS_ITER = 32;

endpackage

// File: rtl/mds_iter_step.sv
// One iteration of the magnitude datapath, purely combinational.
//   op       : OP_MULT = shift-add multiply step, OP_DIV = restoring divide step
//   work     : working register; MULT {upper, lower=multiplier}, DIV {rem, quot}
//   operand  : |A| (multiplicand) for MULT, |B| (divisor) for DIV
//   work_nx  : working register after this iteration
module mds_iter_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] work_nx
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    // Carry out of the upper-half add is kept so the right shift does not lose it.
    sum     = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    shifted = {work[2*WIDTH-2:0], 1'b0};
    // Divisor magnitude is at most 2^(WIDTH-1), so the shifted remainder always
    // fits in WIDTH bits and the extra trial bit is a pure sign bit.
    trial   = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, operand};
    work_nx = work;
    if (op == OP_MULT) begin
      if (work[0]) work_nx = {sum, work[WIDTH-1:1]};
      else         work_nx = {1'b0, work[2*WIDTH-1:1]};
    end else begin
      if (!trial[WIDTH]) work_nx = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
      else               work_nx = shifted;
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer owning the HI/LO registers.
//   Clk, Reset     : clock, asynchronous active-high reset
//   Start, Op      : request (sampled in IDLE only), 0 = MULT, 1 = DIV
//   OpA, OpB       : rs / rt operands, latched when Start is accepted
//   Busy           : high in PREP, RUN and FIX
//   Done, DivZero  : one-cycle completion pulse; DivZero flags a DIV by zero
//   Hi, Lo         : result registers (MULT high/low word, DIV remainder/quotient)
//   State          : current sequencer state, for observation
// Handshake: Start is a request accepted only while idle; the caller must then
// wait for the Done pulse. Requests while busy are dropped, never queued.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output mds_state_t       State
);

  localparam int CW = $clog2(MDS_ITER);

  mds_state_t state, state_nx;

  logic               op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               q_sign, r_sign, dz;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] work, work_nx;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   a_mag, b_mag, step_operand;
  logic [WIDTH-1:0]   quot, rem;

  assign a_mag        = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
  assign b_mag        = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
  assign step_operand = (op_q == OP_MULT) ? a_mag : b_mag;
  assign quot         = work[WIDTH-1:0];
  assign rem          = work[2*WIDTH-1:WIDTH];

  mds_iter_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .work    (work),
    .operand (step_operand),
    .work_nx (work_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (Start) state_nx = PREP;
      PREP: if ((op_q == OP_DIV) && (b_q == '0)) state_nx = DONE;
            else                                 state_nx = RUN;
      RUN:  if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state == PREP) || (state == RUN) || (state == FIX);
    Done    = (state == DONE);
    DivZero = (state == DONE) && dz;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      work   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (Start) begin
          a_q  <= OpA;
          b_q  <= OpB;
          op_q <= Op;
        end
        PREP: begin
          q_sign <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          r_sign <= a_q[WIDTH-1];
          dz     <= (op_q == OP_DIV) && (b_q == '0);
          cnt    <= CW'(MDS_ITER - 1);
          // MULT shifts the multiplier out of the low half; DIV shifts the
          // dividend out of the low half while quotient bits shift in.
          work   <= (op_q == OP_MULT) ? {{WIDTH{1'b0}}, b_mag} : {{WIDTH{1'b0}}, a_mag};
        end
        RUN: begin
          work <= work_nx;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            {hi_q, lo_q} <= q_sign ? (~work + 1'b1) : work;
          end else begin
            lo_q <= q_sign ? (~quot + 1'b1) : quot;
            hi_q <= r_sign ? (~rem + 1'b1) : rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign State = state;

endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: directed vector table, Start-ignore and mid-op reset
// sequences, then random operations checked against a signed-arithmetic model.
module tb_mult_div_seq;
  import mult_div_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Start, Op;
  logic [31:0] OpA, OpB;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;
  mds_state_t  State;

  mult_div_seq #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo), .State(State)
  );

  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  typedef struct {
    logic        op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (op == 1'b0) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = exp_hi;
      lo = exp_lo;
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle cycle after Done.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_dz, input int inject_at);
    int lat = 0;
    int exp_lat;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    exp_lat = (op == 1'b1 && b == 32'd0) ? 2 : 35;
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge Clk); #1;
    Start = 1'b0; OpA = $urandom; OpB = $urandom; Op = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge Clk);
      if (Done) lat = k;
      else begin
        if (Busy !== 1'b1 || DivZero !== 1'b0) busy_ok = 1'b0;
        if (Hi !== exp_hi || Lo !== exp_lo) hold_ok = 1'b0;
      end
      Start = (k == inject_at);
      if (k == inject_at) begin
        OpA = $urandom; OpB = $urandom; Op = 1'($urandom_range(0, 1));
      end
    end
    Start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_hi"}, 64'(Hi), 64'(e_hi));
    chk({tag, "_lo"}, 64'(Lo), 64'(e_lo));
    chk({tag, "_divzero"}, 64'(DivZero), 64'(e_dz));
    chk({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
    exp_hi = e_hi;
    exp_lo = e_lo;
    @(negedge Clk);
    chk({tag, "_done_single"}, 64'(Done), 64'd0);
  endtask

  initial begin
    logic [31:0] rhi, rlo, ra, rb;
    logic        rdz, rop;
    bit          no_done;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{1'b1, 32'd59,       32'd6,        32'd5,        32'd9,        1'b0};
    vecs[5]  = '{1'b1, 32'd100,      32'd0,        32'd5,        32'd9,        1'b1};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
    vecs[7]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[9]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[10] = '{1'b1, 32'd0,        32'd0,        32'h3FFFFFFF, 32'h00000001, 1'b1};
    vecs[11] = '{1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0};

    // Clock/reset
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; OpA = '0; OpB = '0;
    repeat (2) @(negedge Clk);
    chk("reset_outputs", {59'd0, Busy, Done, DivZero}, 64'd0);
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    chk("reset_state", 64'(State), 64'(IDLE));
    Reset = 1'b0;
    @(negedge Clk);
    chk("idle_no_busy", 64'(Busy), 64'd0);

    // Directed vector table, issued back to back
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, 0);

    // Start pulsed again at cycle 10 of a MULT must be ignored
    run_op("mult_restart_ignored", 1'b0, 32'd7, 32'hFFFFFFFD,
           32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 10);

    // Reset at cycle 20 of an operation
    Start = 1'b1; Op = 1'b1; OpA = 32'd1000; OpB = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (20) @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("midreset_outputs", {59'd0, Busy, Done, DivZero}, 64'd0);
    chk("midreset_hilo", {Hi, Lo}, 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    no_done = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Done || Busy) no_done = 1'b0;
    end
    chk("midreset_no_done", 64'(no_done), 64'd1);

    // Random operations against the model
    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2, 3:    rb = 32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, rhi, rlo, rdz);
      run_op($sformatf("rand%0d", i), rop, ra, rb, rhi, rlo, rdz, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
